// File: rtl/arm_mem_arbiter.sv
// Arbiter sharing one single-ported backing memory between instruction fetch and data access.
// Data accesses take priority; a starvation counter bounds how long a waiting fetch can be passed over.
module arm_mem_arbiter #(
    parameter int ADDR_W       = 30,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,
    input  logic              mem_req,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [3:0]        mem_we,
    output logic              mem_done,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_stall,
    input  logic              halt_req,
    output logic              quiesced,
    output logic              bus_req,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic [3:0]        bus_we,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata
);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [2:0] {IDLE, BUS_I, BUS_D, RESP_I, RESP_D} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] starve_cnt;
    logic             grant_d;
    logic             grant_i;
    logic             bus_done;

    assign bus_done  = ((state == BUS_I) || (state == BUS_D)) && bus_ack;
    assign if_stall  = if_req & ~if_done;
    assign mem_stall = mem_req & ~mem_done;
    assign quiesced  = halt_req & (state == IDLE) & ~mem_req;

    // Data wins unless a fetch has already been passed over STARVE_LIMIT times in a row.
    always_comb begin
        grant_d   = 1'b0;
        grant_i   = 1'b0;
        state_nxt = state;
        case (state)
            IDLE: begin
                if (mem_req && (!if_req || halt_req || (starve_cnt < LIMIT))) begin
                    grant_d   = 1'b1;
                    state_nxt = BUS_D;
                end else if (if_req && !halt_req) begin
                    grant_i   = 1'b1;
                    state_nxt = BUS_I;
                end
            end
            BUS_I:   if (bus_ack) state_nxt = RESP_I;
            BUS_D:   if (bus_ack) state_nxt = RESP_D;
            RESP_I:  state_nxt = IDLE;
            RESP_D:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state      <= IDLE;
            starve_cnt <= '0;
            bus_req    <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            bus_we     <= '0;
        end else begin
            state <= state_nxt;
            if (grant_d) begin
                bus_req   <= 1'b1;
                bus_addr  <= mem_addr;
                bus_wdata <= mem_wdata;
                bus_we    <= mem_we;
                if (!if_req)
                    starve_cnt <= '0;
                else if (starve_cnt != LIMIT)
                    starve_cnt <= starve_cnt + CNT_W'(1);
            end else if (grant_i) begin
                bus_req    <= 1'b1;
                bus_addr   <= if_addr;
                bus_we     <= '0;
                starve_cnt <= '0;
            end else if (bus_done) begin
                bus_req <= 1'b0;
            end
        end
    end

    // Read data is captured on the ack edge so it is valid alongside the done pulse.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            if_done   <= 1'b0;
            mem_done  <= 1'b0;
            if_rdata  <= '0;
            mem_rdata <= '0;
        end else begin
            if_done  <= (state == BUS_I) && bus_ack;
            mem_done <= (state == BUS_D) && bus_ack;
            if ((state == BUS_I) && bus_ack)
                if_rdata <= bus_rdata;
            if ((state == BUS_D) && bus_ack && (bus_we == 4'b0000))
                mem_rdata <= bus_rdata;
        end
    end
endmodule

// File: tb/tb_arm_mem_arbiter.sv
// Self-checking bench for arm_mem_arbiter: directed scenarios plus a randomized run
// checked against a cycle-count reference model built from the arbitration rules.
module tb_arm_mem_arbiter;
    localparam int ADDR_W       = 30;
    localparam int DATA_W       = 32;
    localparam int STARVE_LIMIT = 4;

    logic              clk = 1'b0;
    logic              rst_b = 1'b0;
    logic              if_req = 1'b0;
    logic [ADDR_W-1:0] if_addr = '0;
    logic              if_done;
    logic [DATA_W-1:0] if_rdata;
    logic              if_stall;
    logic              mem_req = 1'b0;
    logic [ADDR_W-1:0] mem_addr = '0;
    logic [DATA_W-1:0] mem_wdata = '0;
    logic [3:0]        mem_we = '0;
    logic              mem_done;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_stall;
    logic              halt_req = 1'b0;
    logic              quiesced;
    logic              bus_req;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [3:0]        bus_we;
    logic              bus_ack = 1'b0;
    logic [DATA_W-1:0] bus_rdata = '0;

    int tests = 0;
    int fails = 0;
    logic [DATA_W-1:0] mem_model [0:15];

    arm_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .rst_b(rst_b),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata), .if_stall(if_stall),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_done(mem_done), .mem_rdata(mem_rdata), .mem_stall(mem_stall),
        .halt_req(halt_req), .quiesced(quiesced),
        .bus_req(bus_req), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    // Inputs change just after the rising edge; outputs are observed on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_b = 1'b0; if_req = 1'b1; halt_req = 1'b1; mem_req = 1'b0; bus_ack = 1'b0;
        sample();
        tests++;
        if ({bus_req, bus_addr, bus_wdata, bus_we, if_done, mem_done, if_rdata, mem_rdata} !== '0) begin
            fails++;
            $display("[TB] FAIL reset_regs got req=%0b addr=%h wd=%h we=%h ifd=%0b md=%0b ir=%h mr=%h want all zero",
                     bus_req, bus_addr, bus_wdata, bus_we, if_done, mem_done, if_rdata, mem_rdata);
        end
        tests++;
        if ({if_stall, mem_stall, quiesced} !== 3'b101) begin
            fails++;
            $display("[TB] FAIL reset_comb got %b want 101", {if_stall, mem_stall, quiesced});
        end
        next_cycle();
        rst_b = 1'b1; if_req = 1'b0; halt_req = 1'b0;
        sample();
        tests++;
        if ({bus_req, if_stall, quiesced} !== 3'b000) begin
            fails++;
            $display("[TB] FAIL reset_release got %b want 000", {bus_req, if_stall, quiesced});
        end
    endtask

    task automatic test_lone_fetch();
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            if_req = (k < 3); if_addr = 30'h10;
            bus_ack = (k == 1); bus_rdata = (k == 1) ? 32'hE3A01005 : 32'h0;
            sample();
            tests++;
            if (bus_req !== (k == 1)) begin
                fails++; $display("[TB] FAIL fetch_bus_req k=%0d got %0b want %0b", k, bus_req, k == 1);
            end
            if (k == 1) begin
                tests++;
                if (bus_addr !== 30'h10 || bus_we !== 4'b0000) begin
                    fails++; $display("[TB] FAIL fetch_bus_fields got addr=%h we=%b want 10/0000", bus_addr, bus_we);
                end
            end
            tests++;
            if (if_done !== (k == 2) || if_stall !== (k < 2)) begin
                fails++;
                $display("[TB] FAIL fetch_done_stall k=%0d got %0b%0b want %0b%0b", k, if_done, if_stall, k == 2, k < 2);
            end
            if (k >= 2) begin
                tests++;
                if (if_rdata !== 32'hE3A01005) begin
                    fails++; $display("[TB] FAIL fetch_rdata got %h want e3a01005", if_rdata);
                end
            end
        end
    endtask

    task automatic test_store_load();
        for (int k = 0; k < 7; k++) begin
            next_cycle();
            mem_req = (k < 6); mem_addr = 30'h20; mem_wdata = 32'hAB;
            mem_we = (k < 3) ? 4'b0001 : 4'b0000;
            bus_ack = (k == 1 || k == 4);
            bus_rdata = (k == 1) ? 32'hDEADBEEF : 32'h000000AB;
            sample();
            tests++;
            if (bus_req !== (k == 1 || k == 4) || mem_done !== (k == 2 || k == 5)) begin
                fails++;
                $display("[TB] FAIL store_load_seq k=%0d got req=%0b done=%0b", k, bus_req, mem_done);
            end
            if (k == 1) begin
                tests++;
                if (bus_we !== 4'b0001 || bus_addr !== 30'h20 || bus_wdata !== 32'hAB) begin
                    fails++;
                    $display("[TB] FAIL store_bus got we=%b addr=%h wd=%h want 0001/20/ab", bus_we, bus_addr, bus_wdata);
                end
            end
            if (k == 4) begin
                tests++;
                if (bus_we !== 4'b0000) begin
                    fails++; $display("[TB] FAIL load_bus_we got %b want 0000", bus_we);
                end
            end
            tests++;
            if (mem_rdata !== ((k >= 5) ? 32'hAB : 32'h0)) begin
                fails++;
                $display("[TB] FAIL store_load_rdata k=%0d got %h want %h", k, mem_rdata, (k >= 5) ? 32'hAB : 32'h0);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [ADDR_W-1:0] a_d;
        logic [ADDR_W-1:0] a_i;
        logic [DATA_W-1:0] d_d;
        logic [DATA_W-1:0] d_i;
        a_d = 30'($urandom); a_i = a_d ^ 30'h1; d_d = $urandom; d_i = $urandom;
        for (int k = 0; k < 7; k++) begin
            next_cycle();
            if_req = (k < 6); if_addr = a_i;
            mem_req = (k < 3); mem_addr = a_d; mem_we = 4'b0000;
            bus_ack = (k == 1 || k == 4);
            bus_rdata = (k == 1) ? d_d : d_i;
            sample();
            tests++;
            if (mem_done !== (k == 2) || if_done !== (k == 5) || bus_req !== (k == 1 || k == 4)) begin
                fails++;
                $display("[TB] FAIL simul_seq k=%0d got md=%0b id=%0b req=%0b", k, mem_done, if_done, bus_req);
            end
            if (k == 1 || k == 4) begin
                tests++;
                if (bus_addr !== ((k == 1) ? a_d : a_i)) begin
                    fails++; $display("[TB] FAIL simul_addr k=%0d got %h want %h", k, bus_addr, (k == 1) ? a_d : a_i);
                end
            end
            if (k == 5) begin
                tests++;
                if (if_rdata !== d_i || mem_rdata !== d_d) begin
                    fails++;
                    $display("[TB] FAIL simul_rdata got if=%h mem=%h want %h %h", if_rdata, mem_rdata, d_i, d_d);
                end
            end
        end
    endtask

    task automatic test_starvation();
        int  done_n = 0;
        int  exp_cnt;
        bit  d_prev = 0;
        bit  i_prev = 0;
        bit  want_i;
        if_addr = 30'h100; mem_addr = 30'h200; mem_we = 4'b0000;
        for (int cyc = 0; cyc < 60 && done_n < 10; cyc++) begin
            next_cycle();
            if_req = 1'b1; mem_req = 1'b1;
            if (d_prev) mem_addr = mem_addr + 30'h1;
            if (i_prev) if_addr = if_addr + 30'h1;
            d_prev = 0; i_prev = 0;
            bus_ack = bus_req; bus_rdata = $urandom;
            sample();
            if (if_done || mem_done) begin
                want_i = ((done_n % 5) == 4);
                exp_cnt = want_i ? 0 : (done_n % 5) + 1;
                tests++;
                if (if_done !== want_i || mem_done !== !want_i) begin
                    fails++;
                    $display("[TB] FAIL starve_order n=%0d got if_done=%0b mem_done=%0b want if_done=%0b", done_n, if_done, mem_done, want_i);
                end
                tests++;
                if (dut.starve_cnt !== 3'(exp_cnt)) begin
                    fails++; $display("[TB] FAIL starve_cnt n=%0d got %0d want %0d", done_n, dut.starve_cnt, exp_cnt);
                end
                d_prev = mem_done; i_prev = if_done;
                done_n++;
            end
        end
        tests++;
        if (done_n != 10) begin
            fails++; $display("[TB] FAIL starve_timeout got %0d completions want 10", done_n);
        end
        next_cycle();
        if_req = 1'b0; mem_req = 1'b0; bus_ack = 1'b0;
        sample();
    endtask

    task automatic test_halt_drain();
        logic [DATA_W-1:0] d;
        d = $urandom;
        mem_req = 1'b0;
        for (int k = 0; k < 16; k++) begin
            next_cycle();
            if_req = (k != 8); if_addr = (k < 8) ? 30'h40 : 30'h41;
            halt_req = (k >= 1);
            bus_ack = (k == 6); bus_rdata = d;
            sample();
            tests++;
            if (bus_req !== (k >= 1 && k <= 6) || if_done !== (k == 7) || quiesced !== (k >= 8)) begin
                fails++;
                $display("[TB] FAIL halt_seq k=%0d got req=%0b done=%0b q=%0b want %0b %0b %0b",
                         k, bus_req, if_done, quiesced, k >= 1 && k <= 6, k == 7, k >= 8);
            end
            if (k == 7) begin
                tests++;
                if (if_rdata !== d) begin
                    fails++; $display("[TB] FAIL halt_rdata got %h want %h", if_rdata, d);
                end
            end
        end
        next_cycle();
        if_req = 1'b0; halt_req = 1'b0;
        sample();
    endtask

    task automatic test_reset_mid();
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        a = 30'($urandom); d = $urandom;
        next_cycle();
        mem_req = 1'b1; mem_addr = a; mem_wdata = $urandom; mem_we = 4'b1111; bus_ack = 1'b0;
        next_cycle();
        sample();
        tests++;
        if (bus_req !== 1'b1) begin
            fails++; $display("[TB] FAIL rstmid_pre got bus_req=%0b want 1", bus_req);
        end
        rst_b = 1'b0;
        #1;
        tests++;
        if (bus_req !== 1'b0) begin
            fails++; $display("[TB] FAIL rstmid_async got bus_req=%0b want 0", bus_req);
        end
        mem_req = 1'b0;
        next_cycle();
        next_cycle();
        rst_b = 1'b1;
        for (int k = 0; k < 4; k++) begin
            sample();
            tests++;
            if (mem_done !== 1'b0 || bus_req !== 1'b0 || mem_rdata !== 32'h0) begin
                fails++;
                $display("[TB] FAIL rstmid_after k=%0d got done=%0b req=%0b rdata=%h", k, mem_done, bus_req, mem_rdata);
            end
            next_cycle();
        end
        for (int k = 0; k < 4; k++) begin
            if (k > 0) next_cycle();
            mem_req = (k < 3); mem_we = 4'b0000;
            bus_ack = (k == 1); bus_rdata = d;
            sample();
            tests++;
            if (mem_done !== (k == 2) || bus_req !== (k == 1)) begin
                fails++; $display("[TB] FAIL rstmid_fresh k=%0d got done=%0b req=%0b", k, mem_done, bus_req);
            end
        end
        tests++;
        if (mem_rdata !== d) begin
            fails++; $display("[TB] FAIL rstmid_rdata got %h want %h", mem_rdata, d);
        end
    endtask

    // The model tracks the arbiter purely by cycle numbers: when the bus is owned,
    // when its done pulse is due, and from which cycle it may grant again.
    task automatic test_random();
        bit                in_bus = 0;
        int                done_cyc = -10;
        int                free_at = 0;
        int                delay = 0;
        int                consec = 0;
        bit                x_side_i = 0;
        bit                done_side_i = 0;
        logic [ADDR_W-1:0] x_addr = '0;
        logic [3:0]        x_we = '0;
        logic [DATA_W-1:0] x_wdata = '0;
        bit                done_i_seen = 0;
        bit                done_m_seen = 0;
        bit                exp_if_done;
        bit                exp_mem_done;
        bit                free;
        logic [DATA_W-1:0] exp_if_rdata = '0;
        logic [DATA_W-1:0] exp_mem_rdata = '0;
        for (int i = 0; i < 16; i++) mem_model[i] = $urandom;
        next_cycle();
        rst_b = 1'b0; if_req = 1'b0; mem_req = 1'b0; halt_req = 1'b0; bus_ack = 1'b0;
        next_cycle();
        rst_b = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            next_cycle();
            if (done_i_seen) if_req = 1'b0;
            if (done_m_seen) mem_req = 1'b0;
            done_i_seen = 0; done_m_seen = 0;
            if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1'b1; if_addr = 30'($urandom_range(0, 15));
            end
            if (!mem_req && $urandom_range(0, 2) == 0) begin
                mem_req = 1'b1; mem_addr = 30'($urandom_range(0, 15)); mem_wdata = $urandom;
                mem_we = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0000;
            end
            if ($urandom_range(0, 15) == 0) halt_req = !halt_req;
            bus_ack = 1'b0; bus_rdata = $urandom;
            if (in_bus) begin
                if (delay == 0) begin
                    bus_ack = 1'b1;
                    if (x_we == 4'b0000) bus_rdata = mem_model[x_addr[3:0]];
                end else begin
                    delay--;
                end
            end
            sample();
            free = !in_bus && (c >= free_at);
            exp_if_done = (c == done_cyc) && done_side_i;
            exp_mem_done = (c == done_cyc) && !done_side_i;
            tests++;
            if (bus_req !== in_bus) begin
                fails++; $display("[TB] FAIL rnd_bus_req c=%0d got %0b want %0b", c, bus_req, in_bus);
            end
            if (in_bus) begin
                tests++;
                if (bus_addr !== x_addr || bus_we !== x_we || (x_we != 4'b0000 && bus_wdata !== x_wdata)) begin
                    fails++;
                    $display("[TB] FAIL rnd_bus_fields c=%0d got %h/%b/%h want %h/%b/%h", c, bus_addr, bus_we, bus_wdata, x_addr, x_we, x_wdata);
                end
            end
            tests++;
            if (if_done !== exp_if_done || mem_done !== exp_mem_done) begin
                fails++;
                $display("[TB] FAIL rnd_done c=%0d got %0b%0b want %0b%0b", c, if_done, mem_done, exp_if_done, exp_mem_done);
            end
            tests++;
            if (if_stall !== (if_req & ~exp_if_done) || mem_stall !== (mem_req & ~exp_mem_done)) begin
                fails++; $display("[TB] FAIL rnd_stall c=%0d got %0b%0b", c, if_stall, mem_stall);
            end
            tests++;
            if (quiesced !== (halt_req & free & ~mem_req)) begin
                fails++; $display("[TB] FAIL rnd_quiesced c=%0d got %0b want %0b", c, quiesced, halt_req & free & ~mem_req);
            end
            tests++;
            if (if_rdata !== exp_if_rdata || mem_rdata !== exp_mem_rdata) begin
                fails++;
                $display("[TB] FAIL rnd_rdata c=%0d got %h/%h want %h/%h", c, if_rdata, mem_rdata, exp_if_rdata, exp_mem_rdata);
            end
            if (exp_if_done) done_i_seen = 1;
            if (exp_mem_done) done_m_seen = 1;
            if (in_bus && bus_ack) begin
                in_bus = 0; done_cyc = c + 1; free_at = c + 2; done_side_i = x_side_i;
                if (x_side_i) exp_if_rdata = mem_model[x_addr[3:0]];
                else if (x_we == 4'b0000) exp_mem_rdata = mem_model[x_addr[3:0]];
                else for (int b = 0; b < 4; b++)
                    if (x_we[b]) mem_model[x_addr[3:0]][8*b +: 8] = x_wdata[8*b +: 8];
            end else if (free && (mem_req || (if_req && !halt_req))) begin
                if (mem_req && (!if_req || halt_req || consec < STARVE_LIMIT)) begin
                    x_side_i = 0; x_addr = mem_addr; x_we = mem_we; x_wdata = mem_wdata;
                    consec = if_req ? ((consec < STARVE_LIMIT) ? consec + 1 : consec) : 0;
                end else begin
                    x_side_i = 1; x_addr = if_addr; x_we = 4'b0000; x_wdata = '0;
                    consec = 0;
                end
                in_bus = 1; delay = $urandom_range(0, 3);
            end
        end
        next_cycle();
        if_req = 1'b0; mem_req = 1'b0; halt_req = 1'b0; bus_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lone_fetch();
        test_store_load();
        test_simultaneous();
        test_starvation();
        test_halt_drain();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
